// File: rtl/pc_if.sv
// pc_if: bundle between the decode/execute redirect logic and the PC unit.
//   master modport : redirect/control source (drives requests, reads fetch PC/RAS)
//   slave modport  : pc_unit (reads requests, drives fetch PC, mepc, pulses, RAS view)
// Signals:
//   stall, branch, jal, jalr, trap, mret, call, ret : control requests
//   branch_address, jal_address, jalr_address       : redirect targets
//   address_out, pc_plus4, mepc_out                 : fetch PC, PC+4, saved trap PC
//   redirect, misaligned                            : one-cycle registered pulses
//   ras_top, ras_valid                              : return-address-stack view
interface pc_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            branch;
    logic [XLEN-1:0] branch_address;
    logic            jal;
    logic [XLEN-1:0] jal_address;
    logic            jalr;
    logic [XLEN-1:0] jalr_address;
    logic            trap;
    logic            mret;
    logic            call;
    logic            ret;
    logic [XLEN-1:0] address_out;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] mepc_out;
    logic            redirect;
    logic            misaligned;
    logic [XLEN-1:0] ras_top;
    logic            ras_valid;

    modport master (
        output stall, branch, branch_address, jal, jal_address,
               jalr, jalr_address, trap, mret, call, ret,
        input  address_out, pc_plus4, mepc_out, redirect, misaligned,
               ras_top, ras_valid
    );

    modport slave (
        input  stall, branch, branch_address, jal, jal_address,
               jalr, jalr_address, trap, mret, call, ret,
        output address_out, pc_plus4, mepc_out, redirect, misaligned,
               ras_top, ras_valid
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: RV32I fetch program counter with next-PC selection
// (trap > mret > stall > branch > jal > jalr > sequential), target alignment
// checking, internal mepc for trap entry/return, and a circular return-address
// stack used only for fetch-side return prediction.
// Ports:
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_if slave modport (requests in; PC, mepc, pulses, RAS view out)
module pc_unit #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic clk,
    input  logic rst,
    pc_if.slave  bus
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_TARGET,
        SRC_MISALIGN,
        SRC_TRAP,
        SRC_MRET,
        SRC_HOLD
    } src_e;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] mepc_q;
    logic            redirect_q;
    logic            misaligned_q;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] target;
    logic            redir_req;
    src_e            src;
    logic            ras_en;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;   // next free slot; top entry sits just below
    logic [CW-1:0]   ras_cnt;
    logic [PW-1:0]   top_idx;

    assign pc4     = pc_q + XLEN'(4);
    assign top_idx = ras_ptr - PW'(1);

    always_comb begin
        target    = '0;
        redir_req = bus.branch | bus.jal | bus.jalr;
        if (bus.branch)
            target = bus.branch_address;
        else if (bus.jal)
            target = bus.jal_address;
        else
            target = {bus.jalr_address[XLEN-1:1], 1'b0};

        src = SRC_SEQ;
        if (bus.trap)
            src = SRC_TRAP;
        else if (bus.mret)
            src = SRC_MRET;
        else if (bus.stall)
            src = SRC_HOLD;
        else if (redir_req && (target[1:0] != 2'b00))
            src = SRC_MISALIGN;
        else if (redir_req)
            src = SRC_TARGET;

        // RAS moves only on plain sequential or aligned-redirect edges
        ras_en = (src == SRC_SEQ) || (src == SRC_TARGET);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            mepc_q       <= '0;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
            unique case (src)
                SRC_TRAP: begin
                    mepc_q     <= pc_q;
                    pc_q       <= TRAP_VECTOR;
                    redirect_q <= 1'b1;
                end
                SRC_MISALIGN: begin
                    mepc_q       <= pc_q;
                    pc_q         <= TRAP_VECTOR;
                    redirect_q   <= 1'b1;
                    misaligned_q <= 1'b1;
                end
                SRC_MRET: begin
                    pc_q       <= mepc_q;
                    redirect_q <= 1'b1;
                end
                SRC_TARGET: begin
                    pc_q       <= target;
                    redirect_q <= 1'b1;
                end
                SRC_HOLD: ;
                default: pc_q <= pc4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_mem <= '{default: '0};
        end else if (ras_en) begin
            if (bus.call && bus.ret && (ras_cnt != '0)) begin
                // call+ret on a non-empty stack swaps the top in place
                ras_mem[top_idx] <= pc4;
            end else if (bus.call) begin
                // circular push: when full the oldest slot is overwritten
                ras_mem[ras_ptr] <= pc4;
                ras_ptr          <= ras_ptr + PW'(1);
                if (ras_cnt != CW'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + CW'(1);
            end else if (bus.ret && (ras_cnt != '0)) begin
                ras_ptr <= ras_ptr - PW'(1);
                ras_cnt <= ras_cnt - CW'(1);
            end
        end
    end

    assign bus.address_out = pc_q;
    assign bus.pc_plus4    = pc4;
    assign bus.mepc_out    = mepc_q;
    assign bus.redirect    = redirect_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.ras_valid   = (ras_cnt != '0);
    assign bus.ras_top     = (ras_cnt != '0) ? ras_mem[top_idx] : '0;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test of pc_unit with hand-computed expectations.
module tb_pc_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pc_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall = 0; bus.branch = 0; bus.jal = 0; bus.jalr = 0;
        bus.trap = 0; bus.mret = 0; bus.call = 0; bus.ret = 0;
        bus.branch_address = '0; bus.jal_address = '0; bus.jalr_address = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        idle();
        rst = 1;
        tick();
        chk("rst_pc", bus.address_out, 32'h0);
        chk("rst_mepc", bus.mepc_out, 32'h0);
        chk("rst_redirect", 32'(bus.redirect), 32'h0);
        chk("rst_misaligned", 32'(bus.misaligned), 32'h0);
        chk("rst_ras_valid", 32'(bus.ras_valid), 32'h0);
        chk("rst_ras_top", bus.ras_top, 32'h0);
        chk("rst_pc_plus4", bus.pc_plus4, 32'h4);

        rst = 0;
        tick(); chk("seq1", bus.address_out, 32'h4);
        chk("seq1_redirect", 32'(bus.redirect), 32'h0);
        tick(); chk("seq2", bus.address_out, 32'h8);
        tick(); chk("seq3", bus.address_out, 32'hC);
        chk("seq3_redirect", 32'(bus.redirect), 32'h0);
        rst = 1;
        tick(); chk("mid_rst", bus.address_out, 32'h0);
        rst = 0;

        // branch beats jal
        bus.branch = 1; bus.branch_address = 32'h40;
        bus.jal = 1; bus.jal_address = 32'h80;
        tick(); chk("branch_pc", bus.address_out, 32'h40);
        chk("branch_redirect", 32'(bus.redirect), 32'h1);
        idle();
        tick(); chk("after_branch", bus.address_out, 32'h44);
        chk("redirect_pulse_end", 32'(bus.redirect), 32'h0);

        // stall suppresses branch
        bus.stall = 1; bus.branch = 1; bus.branch_address = 32'h80;
        tick(); chk("stall_hold", bus.address_out, 32'h44);
        chk("stall_redirect", 32'(bus.redirect), 32'h0);
        idle();

        // misaligned jalr target
        bus.jalr = 1; bus.jalr_address = 32'h203;
        tick(); chk("mis_pc", bus.address_out, 32'h100);
        chk("mis_mepc", bus.mepc_out, 32'h44);
        chk("mis_flag", 32'(bus.misaligned), 32'h1);
        chk("mis_redirect", 32'(bus.redirect), 32'h1);
        idle();
        tick(); chk("mis_after", bus.address_out, 32'h104);
        chk("mis_pulse_end", 32'(bus.misaligned), 32'h0);
        bus.mret = 1;
        tick(); chk("mret_pc", bus.address_out, 32'h44);
        chk("mret_redirect", 32'(bus.redirect), 32'h1);
        idle();

        // jalr bit0 cleared, aligned
        bus.jalr = 1; bus.jalr_address = 32'h301;
        tick(); chk("jalr_bit0", bus.address_out, 32'h300);
        chk("jalr_no_mis", 32'(bus.misaligned), 32'h0);
        idle();

        // trap during stall
        bus.branch = 1; bus.branch_address = 32'h20;
        tick(); chk("goto20", bus.address_out, 32'h20);
        idle();
        bus.trap = 1; bus.stall = 1;
        tick(); chk("trap_stall_pc", bus.address_out, 32'h100);
        chk("trap_stall_mepc", bus.mepc_out, 32'h20);
        chk("trap_redirect", 32'(bus.redirect), 32'h1);
        idle();

        // RAS
        rst = 1;
        tick();
        rst = 0;
        bus.call = 1;
        tick(); chk("push1_top", bus.ras_top, 32'h4);
        chk("push1_valid", 32'(bus.ras_valid), 32'h1);
        tick(); tick(); tick(); tick();
        chk("push5_top", bus.ras_top, 32'h14);
        bus.call = 0; bus.ret = 1;
        tick(); chk("pop1_top", bus.ras_top, 32'h10);
        tick(); chk("pop2_top", bus.ras_top, 32'hC);
        tick(); chk("pop3_top", bus.ras_top, 32'h8);
        tick(); chk("pop4_valid", 32'(bus.ras_valid), 32'h0);
        chk("pop4_top", bus.ras_top, 32'h0);
        tick(); chk("pop5_valid", 32'(bus.ras_valid), 32'h0);
        chk("pc_after_pops", bus.address_out, 32'h28);
        bus.call = 1; bus.ret = 1;
        tick(); chk("cr_empty_top", bus.ras_top, 32'h2C);
        tick(); chk("cr_replace_top", bus.ras_top, 32'h30);
        bus.call = 0;
        tick(); chk("cr_count_kept", 32'(bus.ras_valid), 32'h0);
        idle();

        // wrap
        bus.branch = 1; bus.branch_address = 32'hFFFF_FFFC;
        tick(); chk("at_top", bus.address_out, 32'hFFFF_FFFC);
        chk("plus4_wrap", bus.pc_plus4, 32'h0);
        idle();
        tick(); chk("wrap", bus.address_out, 32'h0);
        tick(); chk("after_wrap", bus.address_out, 32'h4);

        // trap beats mret
        bus.trap = 1; bus.mret = 1;
        tick(); chk("trap_mret_pc", bus.address_out, 32'h100);
        chk("trap_mret_mepc", bus.mepc_out, 32'h4);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program-counter unit for the RV32I core.
- Holds the fetch PC and selects the next PC from sequential, branch, jal, jalr, trap and mret sources.
- Adds stall, target-alignment checking, machine-trap entry/return (internal mepc), and a return-address stack (RAS) for fetch-side return prediction.
- Sits between the decode/execute redirect logic and the instruction-memory address port.

Parameters:
- XLEN, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned target.
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold PC; all non-trap updates suppressed.
- branch  in  1  taken conditional branch.
- branch_address  in  XLEN  branch target.
- jal  in  1  jal redirect.
- jal_address  in  XLEN  jal target.
- jalr  in  1  jalr redirect.
- jalr_address  in  XLEN  jalr target (raw; bit0 cleared internally).
- trap  in  1  exception/interrupt request.
- mret  in  1  return from trap.
- call  in  1  current instruction is a call; push pc_out+4.
- ret  in  1  current instruction is a return; pop RAS.
- address_out  out  XLEN  current fetch PC.
- pc_plus4  out  XLEN  address_out+4, combinational.
- mepc_out  out  XLEN  saved trap PC.
- redirect  out  1  one-cycle pulse: last update was non-sequential (flush request).
- misaligned  out  1  one-cycle pulse: misaligned-target trap taken.
- ras_top  out  XLEN  top RAS entry (0 when empty).
- ras_valid  out  1  RAS non-empty.

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-trap or mid-stall):
  - address_out=RESET_VECTOR, mepc_out=0, redirect=0, misaligned=0.
  - RAS count=0 and pointer=0, so ras_valid=0 and ras_top=0.
- Next-PC priority per edge, highest first: trap > mret > stall > branch > jal > jalr > sequential.
- Trap: mepc<=address_out, address_out<=TRAP_VECTOR, redirect=1. Taken even while stall=1.
- Mret (when trap=0): address_out<=mepc_out, redirect=1. Suppressed by stall.
- Stall (when trap=0 and mret=0): all registers hold, including RAS. redirect=0, misaligned=0.
- Redirect (not stalled):
  - Effective target = branch_address, jal_address, or {jalr_address[XLEN-1:1],1'b0}, chosen by priority.
  - If effective target[1:0]!=0: misaligned trap. mepc<=address_out, address_out<=TRAP_VECTOR, misaligned=1, redirect=1. RAS is not updated that cycle.
  - Otherwise: address_out<=target, redirect=1.
- Sequential: address_out<=address_out+4, wrapping modulo 2^XLEN (all-ones-minus-3 + 4 → 0). redirect=0.
- Arithmetic is XLEN-wide; carries are discarded.
- redirect and misaligned are registered. They are valid in the cycle the new address_out appears and are high for exactly one cycle.
- RAS updates only on a non-stalled, non-trap, non-mret, non-misaligned edge:
  - Push on call: write address_out+4 to top, count saturates at RAS_DEPTH. When full, the oldest entry is overwritten (circular buffer).
  - Pop on ret: count decrements. Pop when empty is a no-op; count stays 0.
  - call and ret in the same cycle: replace the top entry with address_out+4; count unchanged. If empty, behave as a push.
  - ras_top and ras_valid are combinational from the registered RAS state.
- The RAS is prediction-only: address_out never reads ras_top. Upstream supplies jalr_address.
- Simultaneous trap and mret: trap wins and mepc is overwritten.

Test Plan:
- Reset then 4 free-running cycles → address_out 0,4,8,12; redirect=0 throughout. Assert rst mid-run → address_out=0 on the next edge.
- branch=1, branch_address=0x40 with jal=1 the same cycle → address_out=0x40 and redirect pulse. With stall=1 instead → address_out holds.
- jalr_address=0x203 → target 0x202 is misaligned → address_out=0x100, mepc_out=previous PC, misaligned pulse. Then mret=1 → address_out returns to the saved PC.
- trap=1 while stall=1 at PC 0x20 → address_out=0x100, mepc_out=0x20.
- Push 5 calls at PCs 0x0,0x4,0x8,0xC,0x10 (RAS_DEPTH=4) → ras_top=0x14. Pop 4 → ras_top 0x10,0xC,0x8, then ras_valid=0. A fifth pop keeps ras_valid=0.
- PC at 0xFFFF_FFFC with sequential advance → address_out=0x0.
